pipeline_hazard_unit: RTL

- Parametrised hazard and forwarding controller for the in-order RISC-V pipeline. It sits beside decode_stage and tracks in-flight instructions from execute through write-back.
- Each cycle it decides whether decode must stall and which stage supplies each source operand. Forwarding/interlock mode, pipe depth and load latency are generic.
- It also owns the stall/forward performance counters.

---
 rtl/hazard_pkg.sv | 19 +
 rtl/hazard_match.sv | 34 +++
 rtl/pipeline_hazard_unit.sv | 101 ++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and helpers for the pipeline hazard unit
package hazard_pkg;

  // Tracked rd fields are stored at this width; narrower register indices are zero-extended.
  localparam int RD_W_MAX = 8;
  localparam int FWD_RF   = 0;

  typedef struct packed {
    logic                valid;
    logic [RD_W_MAX-1:0] rd;
    logic                we;
    logic                is_load;
  } entry_t;

  function automatic int fsw_of(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// rtl/hazard_match.sv - priority search of one source register against tracked entries
module hazard_match
  import hazard_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int REG_AW = 5,
  parameter int FSW    = fsw_of(DEPTH)
) (
  input  logic [REG_AW-1:0]  src,
  input  logic               used,
  input  entry_t [DEPTH-1:0] ents,
  output logic               hit,
  output logic [FSW-1:0]     idx,
  output logic               is_load
);

  logic [RD_W_MAX-1:0] src_ext;
  assign src_ext = RD_W_MAX'(src);

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    hit     = 1'b0;
    idx     = '0;
    is_load = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (used && (src != '0) && ents[i].valid && ents[i].we && (ents[i].rd == src_ext)) begin
        hit     = 1'b1;
        idx     = FSW'(i);
        is_load = ents[i].is_load;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// rtl/pipeline_hazard_unit.sv - decode stall and operand forwarding control with perf counters
module pipeline_hazard_unit
  import hazard_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int REG_AW   = 5,
  parameter int FWD_EN   = 1,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32,
  parameter int FSW      = fsw_of(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rd_we,
  input  logic              id_is_load,
  input  logic              mem_busy,
  input  logic              flush,
  output logic              stall_o,
  output logic [FSW-1:0]    fwd_rs1_o,
  output logic [FSW-1:0]    fwd_rs2_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  fwd_cnt_o
);

  localparam logic [FSW-1:0] LOAD_LAT_F = FSW'(LOAD_LAT);

  entry_t [DEPTH-1:0] ents;
  entry_t             new_ent;
  logic               hit1, hit2, ld1, ld2;
  logic [FSW-1:0]     idx1, idx2;
  logic               hz1, hz2, hazard, accept;
  logic [FSW-1:0]     fwd1, fwd2;
  logic [1:0]         fwd_inc;
  logic [CNT_W-1:0]   stall_cnt, fwd_cnt;

  hazard_match #(.DEPTH(DEPTH), .REG_AW(REG_AW), .FSW(FSW)) u_match_rs1 (
    .src(id_rs1), .used(id_rs1_used), .ents(ents), .hit(hit1), .idx(idx1), .is_load(ld1)
  );

  hazard_match #(.DEPTH(DEPTH), .REG_AW(REG_AW), .FSW(FSW)) u_match_rs2 (
    .src(id_rs2), .used(id_rs2_used), .ents(ents), .hit(hit2), .idx(idx2), .is_load(ld2)
  );

  always_comb begin
    if (FWD_EN != 0) begin
      // Only a load still inside its latency window blocks forwarding.
      hz1 = hit1 & ld1 & (idx1 < LOAD_LAT_F);
      hz2 = hit2 & ld2 & (idx2 < LOAD_LAT_F);
    end else begin
      hz1 = hit1;
      hz2 = hit2;
    end
    hazard = id_valid & (hz1 | hz2);
    accept = id_valid & ~hazard & ~flush;
    fwd1   = FSW'(FWD_RF);
    fwd2   = FSW'(FWD_RF);
    if (!rst && id_valid && (FWD_EN != 0) && !hazard) begin
      if (hit1) fwd1 = idx1 + FSW'(1);
      if (hit2) fwd2 = idx2 + FSW'(1);
    end
    new_ent         = '0;
    new_ent.valid   = accept;
    new_ent.rd      = accept ? RD_W_MAX'(id_rd) : '0;
    new_ent.we      = accept & id_rd_we;
    new_ent.is_load = accept & id_is_load;
  end

  assign fwd_inc = accept ? (2'(fwd1 != '0) + 2'(fwd2 != '0)) : 2'd0;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, c} + (CNT_W + 1)'(inc);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      ents      <= '0;
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else if (!mem_busy) begin
      for (int i = DEPTH - 1; i > 0; i--) ents[i] <= ents[i-1];
      ents[0] <= new_ent;
      if (hazard && !flush) stall_cnt <= sat_add(stall_cnt, 2'd1);
      fwd_cnt <= sat_add(fwd_cnt, fwd_inc);
    end
  end

  assign stall_o     = ~rst & ((hazard & ~flush) | mem_busy);
  assign fwd_rs1_o   = fwd1;
  assign fwd_rs2_o   = fwd2;
  assign stall_cnt_o = stall_cnt;
  assign fwd_cnt_o   = fwd_cnt;

endmodule
